// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues req/ack fetches to
// instruction memory and buffers {pc, instruction} pairs in a small FIFO
// that decode drains over a valid/ready handshake. A redirect flushes the
// buffer and restarts fetch at the new PC.
//
// Ports:
//   clock, reset          system clock; synchronous active-low reset
//   imem_req/imem_addr    fetch request and word-aligned fetch address
//   imem_ack/imem_rdata   memory accept and returned instruction word
//   redirect/redirect_pc  flush and restart fetch at redirect_pc
//   ins_valid/ins/ins_pc  FIFO head (ins and ins_pc are 0 when empty)
//   ins_ready             decode consumes the head when ins_valid is high
//   fifo_count            current FIFO occupancy
module fetch_prefetch_unit #(
    parameter int unsigned         BITSIZE  = 32,
    parameter int unsigned         DEPTH    = 4,
    parameter logic [BITSIZE-1:0]  RESET_PC = '0
) (
    input  logic                    clock,
    input  logic                    reset,
    output logic                    imem_req,
    output logic [BITSIZE-1:0]      imem_addr,
    input  logic                    imem_ack,
    input  logic [BITSIZE-1:0]      imem_rdata,
    input  logic                    redirect,
    input  logic [BITSIZE-1:0]      redirect_pc,
    output logic                    ins_valid,
    output logic [BITSIZE-1:0]      ins,
    output logic [BITSIZE-1:0]      ins_pc,
    input  logic                    ins_ready,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT      = 2'd1,
        S_WAIT_DROP = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [BITSIZE-1:0] fetch_pc, fetch_pc_next;
    logic [BITSIZE-1:0] drop_pc, drop_pc_next;
    logic [AW-1:0]      rd_ptr, wr_ptr;
    logic [CW-1:0]      count, count_after;
    logic [BITSIZE-1:0] mem_pc  [DEPTH];
    logic [BITSIZE-1:0] mem_ins [DEPTH];
    logic               push, pop;
    logic [BITSIZE-1:0] redirect_aligned;

    // State and fetch-PC registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
            drop_pc  <= '0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            drop_pc  <= drop_pc_next;
        end
    end

    // Next-state, next-PC and FIFO occupancy
    always_comb begin
        state_next       = state;
        fetch_pc_next    = fetch_pc;
        drop_pc_next     = drop_pc;
        redirect_aligned = redirect_pc & ~BITSIZE'(3);
        pop              = (count != '0) && ins_ready;
        push             = (state == S_WAIT) && imem_ack && !redirect;
        count_after      = count + CW'(push) - CW'(pop);

        if (redirect) begin
            case (state)
                S_WAIT, S_WAIT_DROP: begin
                    if (imem_ack) begin
                        // Outstanding request completes now; its data is dropped.
                        state_next    = S_WAIT;
                        fetch_pc_next = redirect_aligned;
                    end else begin
                        // Address must stay put until the pending ack arrives.
                        state_next   = S_WAIT_DROP;
                        drop_pc_next = redirect_aligned;
                    end
                end
                default: begin
                    state_next    = S_WAIT;
                    fetch_pc_next = redirect_aligned;
                end
            endcase
        end else begin
            case (state)
                S_IDLE: begin
                    if (count_after < CW'(DEPTH)) state_next = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_ack) begin
                        fetch_pc_next = fetch_pc + BITSIZE'(4);
                        state_next    = (count_after < CW'(DEPTH)) ? S_WAIT : S_IDLE;
                    end
                end
                S_WAIT_DROP: begin
                    if (imem_ack) begin
                        fetch_pc_next = drop_pc;
                        state_next    = S_WAIT;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // FIFO pointers and occupancy; redirect clears the buffer
    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_after;
        end
    end

    // FIFO storage
    always_ff @(posedge clock) begin
        if (push) begin
            mem_pc[wr_ptr]  <= fetch_pc;
            mem_ins[wr_ptr] <= imem_rdata;
        end
    end

    assign imem_req   = (state != S_IDLE);
    assign imem_addr  = fetch_pc;
    assign fifo_count = count;
    assign ins_valid  = (count != '0);
    assign ins        = ins_valid ? mem_ins[rd_ptr] : '0;
    assign ins_pc     = ins_valid ? mem_pc[rd_ptr]  : '0;

endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
- Instruction fetch stage directly upstream of the single-cycle datapath. It owns the fetch PC and drives a req/ack instruction-memory port.
- Fetched words are buffered, with their PCs, in a small FIFO. Decode pulls instructions from the FIFO over a valid/ready handshake.
- A taken branch or jump applies a redirect, which flushes the buffer and restarts fetch at the new PC.

Parameters:
- BITSIZE, 32, width of PC and instruction words.
- DEPTH, 4, prefetch FIFO entries (power of two, 2..16).
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  reset, synchronous, active-low (0 = reset).
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  BITSIZE  word-aligned fetch address; stable while imem_req=1 and imem_ack=0.
- imem_ack  input  1  memory accepts request and returns data this cycle; ignored when imem_req=0.
- imem_rdata  input  BITSIZE  instruction word, valid when imem_req & imem_ack.
- redirect  input  1  flush and restart fetch (branch/jump taken).
- redirect_pc  input  BITSIZE  new fetch PC, sampled when redirect=1.
- ins_valid  output  1  FIFO head holds an instruction.
- ins  output  BITSIZE  head instruction; 0 when ins_valid=0.
- ins_pc  output  BITSIZE  PC of head instruction; 0 when ins_valid=0.
- ins_ready  input  1  decode consumes head when ins_valid & ins_ready.
- fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset=0 at an edge):
  - State goes to IDLE; imem_req=0; fetch_pc=RESET_PC; FIFO empty; fifo_count=0; ins_valid=0.
  - Any in-flight request is abandoned.
  - First imem_req is asserted in the first cycle after reset deasserts.
- imem_addr = fetch_pc at all times. fetch_pc advances by 4 on each accepted ack and wraps modulo 2^BITSIZE.
- State machine, with imem_req = (state != IDLE):
  - IDLE: go to WAIT when occupancy < DEPTH.
  - WAIT:
    - On ack, push {fetch_pc, imem_rdata} into the FIFO and set fetch_pc += 4.
    - Stay in WAIT if the post-push/pop occupancy < DEPTH; otherwise go to IDLE.
    - This gives back-to-back fetches at 1 word/cycle with a zero-wait memory.
  - WAIT_DROP: request still pending but its response must be discarded. On ack, nothing is pushed; go to WAIT (the request to fetch_pc is then presented).
- Occupancy rule: a new request is launched only if FIFO count after this cycle's push/pop is < DEPTH, so an ack can never overflow the FIFO.
  - Push and pop in the same cycle is legal at any occupancy.
  - Pop when empty is ignored.
- Outputs ins, ins_pc and ins_valid come straight from the FIFO head registers. There is no combinational path from imem_rdata to ins.
- Latency: an ack in cycle t makes the instruction visible at ins in cycle t+1 if the FIFO was empty.
- Redirect, highest priority below reset:
  - The FIFO is cleared at the edge; fifo_count becomes 0 and ins_valid becomes 0 next cycle.
  - A valid/ready transfer in the redirect cycle still counts as completed.
  - fetch_pc takes redirect_pc (low 2 bits forced to 0).
  - Redirect during IDLE, or during WAIT with ack in the same cycle: the acked data is discarded; next state is WAIT at redirect_pc.
  - Redirect during WAIT without ack: go to WAIT_DROP. imem_addr keeps the old address until ack (address-stability rule), then switches to redirect_pc.
  - Redirect during WAIT_DROP: stay in WAIT_DROP; the newest redirect_pc overwrites the pending target.
- FIFO pointers wrap modulo DEPTH.

Test Plan:
- Reset then zero-wait memory (ack tied to req, rdata=addr+32'h100), ins_ready=1: ins_pc sequence 0,4,8,... with ins=0x100,0x104,...; ins_valid is high from cycle 2 onward and one instruction is delivered per cycle.
- ins_ready=0 with zero-wait memory: exactly 4 acks, fifo_count=4, imem_req drops. Then ins_ready=1 for 1 cycle: one pop, and imem_req reasserts at addr 0x10 the next cycle.
- Memory with 3-cycle ack latency, redirect to 0x200 in the first wait cycle of the fetch to 0x0: imem_addr stays 0x0 until ack, the response is not pushed, the next request goes to 0x200, and the first ins_pc seen is 0x200.
- FIFO holding 0x0..0xC, redirect to 0x80 together with ins_ready=1: head 0x0 is consumed, fifo_count=0 next cycle, and no stale PC (0x4..0x10) ever appears at ins_pc.
- Reset asserted (reset=0) while imem_req=1 and un-acked, and FIFO at count 2: the next cycle has imem_req=0, fifo_count=0 and ins_valid=0. After release, fetch restarts at RESET_PC.
- redirect_pc=32'hFFFF_FFFC with zero-wait memory: ins_pc 0xFFFFFFFC is followed by 0x00000000 (wrap); redirect_pc=0x203 fetches from 0x200.
